// File: rtl/store_buf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_buf_pkg                                                            |
// | Shared width encodings, entry layout and bus-alignment helper for the    |
// | store merge buffer.                                                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package store_buf_pkg;

    typedef enum logic [1:0] {
        W_WORD = 2'b00,
        W_HALF = 2'b01,
        W_BYTE = 2'b10,
        W_FULL = 2'b11
    } st_width_e;

    // Entry layout for the core's native 32-bit bus; wider builds use the same field order.
    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  byteen;
        logic [31:0] wdata;
    } entry_t;

    function automatic logic [63:0] bus_align(input logic [63:0] addr, input int unsigned lg_bytes);
        return addr & ~((64'd1 << lg_bytes) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_lane_align                                                         |
// | Checks store alignment and places the low bytes of the store data onto  |
// | the enabled bus byte lanes.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module store_lane_align
    import store_buf_pkg::*;
#(
    parameter  int DATA_W  = 32,
    localparam int c_BYTES = DATA_W / 8,
    localparam int c_LG    = $clog2(DATA_W / 8)
) (
    input  logic [1:0]         i_width,
    input  logic [c_LG-1:0]    i_offset,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic               o_aligned,
    output logic [c_BYTES-1:0] o_byteen,
    output logic [DATA_W-1:0]  o_lane_data
);

    int w_size;

    always_comb begin
        w_size    = 1;
        o_aligned = 1'b1;
        case (st_width_e'(i_width))
            W_BYTE: w_size = 1;
            W_HALF: begin
                w_size    = 2;
                o_aligned = ~i_offset[0];
            end
            W_WORD: begin
                w_size    = 4;
                o_aligned = (i_offset[1:0] == 2'b00);
            end
            default: begin
                w_size    = c_BYTES;
                o_aligned = (i_offset == '0);
            end
        endcase

        o_byteen    = '0;
        o_lane_data = '0;
        // Aligned sizes divide the offset, so lane i carries source byte (i mod size).
        for (int i = 0; i < c_BYTES; i++) begin
            o_byteen[i] = o_aligned && (i >= int'(i_offset)) && (i < int'(i_offset) + w_size);
            if (o_byteen[i]) begin
                o_lane_data[8*i +: 8] = i_wdata[8*(i & (w_size - 1)) +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_merge_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_merge_buffer                                                       |
// | Store path: lane alignment, LL/SC link, merging FIFO and bus drain.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module store_merge_buffer
    import store_buf_pkg::*;
#(
    parameter  int DATA_W  = 32,
    parameter  int ADDR_W  = 32,
    parameter  int DEPTH   = 4,
    localparam int c_BYTES = DATA_W / 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               st_valid,
    input  logic [1:0]         st_width,
    input  logic [ADDR_W-1:0]  st_addr,
    input  logic [DATA_W-1:0]  st_wdata,
    input  logic               st_is_sc,
    input  logic               ll_valid,
    input  logic [ADDR_W-1:0]  ll_addr,
    input  logic               link_clr,
    output logic               st_ready,
    output logic               sc_result,
    output logic               misalign,
    input  logic [ADDR_W-1:0]  ld_addr,
    output logic               ld_hazard,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [ADDR_W-1:0]  m_addr,
    output logic [c_BYTES-1:0] m_byteen,
    output logic [DATA_W-1:0]  m_wdata,
    output logic               empty
);

    localparam int unsigned c_LG    = $clog2(c_BYTES);
    localparam int          c_PTR_W = $clog2(DEPTH);
    localparam int          c_CNT_W = c_PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [c_BYTES-1:0] byteen;
        logic [DATA_W-1:0]  wdata;
    } sb_entry_t;

    function automatic logic [ADDR_W-1:0] f_align(input logic [ADDR_W-1:0] a);
        return ADDR_W'(bus_align(64'(a), c_LG));
    endfunction

    sb_entry_t           r_entry_q [DEPTH];
    sb_entry_t           w_entry_d [DEPTH];
    logic [c_PTR_W-1:0]  r_head_q, w_head_d, r_tail_q, w_tail_d;
    logic [c_CNT_W-1:0]  r_count_q, w_count_d;
    logic                r_link_valid_q, w_link_valid_d;
    logic [ADDR_W-1:0]   r_link_addr_q, w_link_addr_d;

    logic                w_lane_ok;
    logic [c_BYTES-1:0]  w_lane_be;
    logic [DATA_W-1:0]   w_lane_data;
    logic                w_st_ready, w_accept, w_aligned_acc, w_link_hit;
    logic                w_store, w_merge, w_push, w_pop, w_m_valid;
    logic [ADDR_W-1:0]   w_st_baddr, w_ld_baddr;
    logic [c_PTR_W-1:0]  w_young;

    store_lane_align #(.DATA_W(DATA_W)) u_align (
        .i_width     (st_width),
        .i_offset    (st_addr[c_LG-1:0]),
        .i_wdata     (st_wdata),
        .o_aligned   (w_lane_ok),
        .o_byteen    (w_lane_be),
        .o_lane_data (w_lane_data)
    );

    always_comb begin
        w_st_ready    = (r_count_q != c_CNT_W'(DEPTH));
        w_accept      = st_valid & w_st_ready;
        w_aligned_acc = w_accept & w_lane_ok;
        w_st_baddr    = f_align(st_addr);
        w_link_hit    = r_link_valid_q & (r_link_addr_q == w_st_baddr);
        w_store       = w_aligned_acc & (~st_is_sc | w_link_hit);
        w_m_valid     = (r_count_q != '0);
        w_pop         = w_m_valid & m_ready;
        w_young       = r_tail_q - c_PTR_W'(1);
        // Merging into an entry that leaves this cycle would lose the new bytes.
        w_merge       = w_store & w_m_valid & (r_entry_q[w_young].addr == w_st_baddr)
                        & ~(w_pop & (w_young == r_head_q));
        w_push        = w_store & ~w_merge;
    end

    always_comb begin
        w_entry_d = r_entry_q;
        if (w_merge) begin
            w_entry_d[w_young].byteen = r_entry_q[w_young].byteen | w_lane_be;
            for (int i = 0; i < c_BYTES; i++) begin
                if (w_lane_be[i]) begin
                    w_entry_d[w_young].wdata[8*i +: 8] = w_lane_data[8*i +: 8];
                end
            end
        end
        if (w_push) begin
            w_entry_d[r_tail_q].addr   = w_st_baddr;
            w_entry_d[r_tail_q].byteen = w_lane_be;
            w_entry_d[r_tail_q].wdata  = w_lane_data;
        end
        w_head_d  = r_head_q + c_PTR_W'(w_pop);
        w_tail_d  = r_tail_q + c_PTR_W'(w_push);
        w_count_d = r_count_q + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

        w_link_valid_d = r_link_valid_q;
        w_link_addr_d  = r_link_addr_q;
        if (link_clr) begin
            w_link_valid_d = 1'b0;
        end else if (ll_valid) begin
            w_link_valid_d = 1'b1;
            w_link_addr_d  = f_align(ll_addr);
        end else if (w_aligned_acc & w_link_hit) begin
            w_link_valid_d = 1'b0;
        end
    end

    always_comb begin : b_hazard
        logic [c_PTR_W-1:0] rel;
        w_ld_baddr = f_align(ld_addr);
        ld_hazard  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel = c_PTR_W'(i) - r_head_q;
            if (({1'b0, rel} < r_count_q) && (r_entry_q[i].addr == w_ld_baddr)) begin
                ld_hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entry_q[i] <= '0;
            end
            r_head_q       <= '0;
            r_tail_q       <= '0;
            r_count_q      <= '0;
            r_link_valid_q <= 1'b0;
            r_link_addr_q  <= '0;
        end else begin
            r_entry_q      <= w_entry_d;
            r_head_q       <= w_head_d;
            r_tail_q       <= w_tail_d;
            r_count_q      <= w_count_d;
            r_link_valid_q <= w_link_valid_d;
            r_link_addr_q  <= w_link_addr_d;
        end
    end

    assign st_ready  = w_st_ready;
    assign sc_result = w_aligned_acc & st_is_sc & w_link_hit;
    assign misalign  = w_accept & ~w_lane_ok;
    assign m_valid   = w_m_valid;
    assign empty     = ~w_m_valid;
    assign m_addr    = w_m_valid ? r_entry_q[r_head_q].addr   : '0;
    assign m_byteen  = w_m_valid ? r_entry_q[r_head_q].byteen : '0;
    assign m_wdata   = w_m_valid ? r_entry_q[r_head_q].wdata  : '0;

endmodule
`default_nettype wire
